// File: rtl/memoria_volcado.sv
// memoria_volcado: dumps CELDAS words of the data memory over a byte-wide
// UART transmitter. Each word goes out least-significant byte first. The
// bench of a byte is held until the transmitter reports it sent. A stalled
// transmitter aborts the dump with a one-cycle error pulse.
module memoria_volcado #(
    parameter int NBITS   = 32,
    parameter int CELDAS  = 16,
    parameter int TIMEOUT = 100000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_Start,
    input  logic             i_TxDone,
    input  logic [NBITS-1:0] i_DebugDato,
    output logic [NBITS-1:0] o_DebugDireccion,
    output logic             o_TxStart,
    output logic [7:0]       o_TxDato,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Error
);

    localparam int NBYTES = NBITS / 8;
    localparam int WW     = (CELDAS > 1) ? $clog2(CELDAS) : 1;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [WW-1:0] LAST_WORD = WW'(CELDAS - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [CW-1:0] LAST_CYC  = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        NEXT,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WW-1:0]    word, word_next;
    logic [BW-1:0]    idx, idx_next;
    logic [CW-1:0]    cyc, cyc_next;
    logic [NBITS-1:0] shreg, shreg_next;
    logic             timeout;

    // Next-state logic together with the next values of the counters and the shift register.
    always_comb begin
        state_next = state;
        word_next  = word;
        idx_next   = idx;
        cyc_next   = cyc;
        shreg_next = shreg;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (i_Start) begin
                    word_next  = '0;
                    idx_next   = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                shreg_next = i_DebugDato;
                state_next = SEND;
            end
            SEND: begin
                cyc_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (i_TxDone) begin
                    state_next = NEXT;
                end else if (cyc == LAST_CYC) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cyc_next = cyc + 1'b1;
                end
            end
            NEXT: begin
                if (idx != LAST_BYTE) begin
                    idx_next   = idx + 1'b1;
                    shreg_next = shreg >> 8;
                    state_next = SEND;
                end else if (word != LAST_WORD) begin
                    idx_next   = '0;
                    word_next  = word + 1'b1;
                    state_next = LOAD;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters and the shift register; reset aborts any dump in progress.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            word  <= '0;
            idx   <= '0;
            cyc   <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            word  <= word_next;
            idx   <= idx_next;
            cyc   <= cyc_next;
            shreg <= shreg_next;
        end
    end

    // Registered outputs, decoded from the state being entered so that they line up with it.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_DebugDireccion <= '0;
            o_TxStart        <= 1'b0;
            o_TxDato         <= '0;
            o_Busy           <= 1'b0;
            o_Done           <= 1'b0;
            o_Error          <= 1'b0;
        end else begin
            o_DebugDireccion <= (state_next == IDLE) ? '0 : NBITS'(word_next);
            o_TxStart        <= (state_next == SEND);
            if (state_next == SEND) begin
                o_TxDato <= shreg_next[7:0];
            end
            o_Busy  <= (state_next != IDLE);
            o_Done  <= (state_next == DONE);
            o_Error <= timeout;
        end
    end

endmodule

// File: tb/tb_memoria_volcado.sv
// Testbench for memoria_volcado: a memory model, an automatic UART responder
// and a byte-stream model checked on every cycle, plus directed scenarios.
module tb_memoria_volcado;

    localparam int NBITS   = 32;
    localparam int CELDAS  = 16;
    localparam int TIMEOUT = 20;
    localparam int NTOTAL  = CELDAS * NBITS / 8;

    logic             clk;
    logic             i_reset;
    logic             i_Start;
    logic             i_TxDone;
    logic [NBITS-1:0] debug_dato;
    logic [NBITS-1:0] o_DebugDireccion;
    logic             o_TxStart;
    logic [7:0]       o_TxDato;
    logic             o_Busy;
    logic             o_Done;
    logic             o_Error;

    logic [31:0] mem [CELDAS];

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    // model / scoreboard state
    int   exp_idx = 0;
    int   tx_count = 0;
    int   done_count = 0;
    int   err_count = 0;
    bit   err_ok = 0;
    logic [7:0] last_byte = 0;
    logic [7:0] cap [4];
    int   cap_n = 0;

    // responder controls
    bit   inject = 0;
    bit   withhold = 0;
    int   withhold_n = 0;
    int   n_seen = 0;
    int   s7_cycle = 0;

    memoria_volcado #(
        .NBITS(NBITS),
        .CELDAS(CELDAS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_Start(i_Start),
        .i_TxDone(i_TxDone),
        .i_DebugDato(debug_dato),
        .o_DebugDireccion(o_DebugDireccion),
        .o_TxStart(o_TxStart),
        .o_TxDato(o_TxDato),
        .o_Busy(o_Busy),
        .o_Done(o_Done),
        .o_Error(o_Error)
    );

    assign debug_dato = (o_DebugDireccion < CELDAS) ? mem[o_DebugDireccion[3:0]] : '0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // UART responder: i_TxDone three cycles after each o_TxStart, optional
    // withholding, optional stray pulses during LOAD and SEND.
    initial begin
        int   pending;
        bit   td;
        bit   prev_busy;
        logic [NBITS-1:0] prev_addr;
        pending = 0;
        prev_busy = 0;
        prev_addr = 0;
        i_TxDone = 0;
        forever begin
            @(negedge clk);
            td = 0;
            if (!i_reset) begin
                pending = 0;
            end else begin
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) td = 1;
                end
                if (o_TxStart) begin
                    n_seen++;
                    if (n_seen == 7) s7_cycle = cycle;
                    if (!(withhold && n_seen == withhold_n)) pending = 3;
                end
                if (inject && (o_TxStart ||
                    (o_Busy && (!prev_busy || o_DebugDireccion != prev_addr)))) td = 1;
            end
            prev_busy = o_Busy;
            prev_addr = o_DebugDireccion;
            i_TxDone = td;
        end
    end

    // Stream model: byte k of a dump is byte (k%4) of word k/4, sent while
    // the address shows that word; o_TxDato holds between sends.
    initial begin
        int w;
        int b;
        logic [31:0] wv;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                if (o_TxStart) begin
                    if (exp_idx < NTOTAL) begin
                        w  = exp_idx / 4;
                        b  = exp_idx % 4;
                        wv = mem[w] >> (8 * b);
                        chk($sformatf("txdato[%0d]", exp_idx), {24'h0, o_TxDato}, {24'h0, wv[7:0]});
                        chk($sformatf("addr[%0d]", exp_idx), o_DebugDireccion, w);
                    end else begin
                        chk("extra_txstart", exp_idx, NTOTAL - 1);
                    end
                    if (o_DebugDireccion == 2 && cap_n < 4) begin
                        cap[cap_n] = o_TxDato;
                        cap_n++;
                    end
                    last_byte = o_TxDato;
                    exp_idx++;
                    tx_count++;
                end else if (o_Busy && tx_count > 0) begin
                    chk("txdato_hold", {24'h0, o_TxDato}, {24'h0, last_byte});
                end
                if (o_Done) begin
                    done_count++;
                    chk("done_after_all_bytes", exp_idx, NTOTAL);
                end
                if (o_Error) begin
                    err_count++;
                    chk("error_expected", {31'h0, err_ok}, 1);
                end
            end
        end
    end

    task automatic clear_model();
        exp_idx = 0;
        tx_count = 0;
        done_count = 0;
        err_count = 0;
        cap_n = 0;
        n_seen = 0;
    endtask

    task automatic start_dump();
        @(negedge clk);
        #1;
        clear_model();
        i_Start = 1;
        @(negedge clk);
        i_Start = 0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!o_Done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!o_Done) chk({name, "_done_timeout"}, 0, 1);
        #1;
    endtask

    task automatic idle_check(input string name, input int ncyc, input int txs);
        repeat (ncyc) @(negedge clk);
        chk({name, "_busy_low"}, {31'h0, o_Busy}, 0);
        chk({name, "_tx_count"}, tx_count, txs);
    endtask

    initial begin
        int n;
        int err_cycle;
        i_reset = 0;
        i_Start = 0;
        for (int i = 0; i < CELDAS; i++) mem[i] = i;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_addr", o_DebugDireccion, 0);
        chk("rst_txstart", {31'h0, o_TxStart}, 0);
        chk("rst_txdato", {24'h0, o_TxDato}, 0);
        chk("rst_busy", {31'h0, o_Busy}, 0);
        chk("rst_done", {31'h0, o_Done}, 0);
        chk("rst_error", {31'h0, o_Error}, 0);
        i_reset = 1;
        idle_check("post_reset", 10, 0);

        // full dump, memory[i] = i
        start_dump();
        wait_done("dump_a");
        chk("a_count", tx_count, 64);
        chk("a_done", done_count, 1);
        @(negedge clk);
        chk("a_busy_after", {31'h0, o_Busy}, 0);

        // word 2 pattern with stray i_TxDone in LOAD and SEND
        mem[2] = 32'hA1B2C3D4;
        inject = 1;
        start_dump();
        wait_done("dump_b");
        inject = 0;
        chk("b_count", tx_count, 64);
        chk("b_cap_n", cap_n, 4);
        chk("b_byte0", {24'h0, cap[0]}, 32'hD4);
        chk("b_byte1", {24'h0, cap[1]}, 32'hC3);
        chk("b_byte2", {24'h0, cap[2]}, 32'hB2);
        chk("b_byte3", {24'h0, cap[3]}, 32'hA1);

        // second i_Start during word 5 is ignored
        start_dump();
        n = 0;
        while (o_DebugDireccion != 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("c_reach_word5", o_DebugDireccion, 5);
        i_Start = 1;
        @(negedge clk);
        i_Start = 0;
        wait_done("dump_c");
        idle_check("c", 40, 64);
        chk("c_done", done_count, 1);

        // i_Start held through DONE and the following IDLE cycle
        start_dump();
        wait_done("dump_e1");
        clear_model();
        i_Start = 1;
        @(negedge clk);
        chk("e_idle_after_done", {31'h0, o_Busy}, 0);
        @(negedge clk);
        i_Start = 0;
        chk("e_restart_busy", {31'h0, o_Busy}, 1);
        wait_done("dump_e2");
        chk("e_count", tx_count, 64);

        // timeout after the 7th byte
        withhold = 1;
        withhold_n = 7;
        err_ok = 1;
        start_dump();
        n = 0;
        while (!o_Error && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("d_error_seen", {31'h0, o_Error}, 1);
        err_cycle = cycle;
        chk("d_error_latency", err_cycle - (s7_cycle + 1), TIMEOUT);
        chk("d_tx_count", tx_count, 7);
        chk("d_done", done_count, 0);
        chk("d_busy", {31'h0, o_Busy}, 0);
        #1;
        err_ok = 0;
        withhold = 0;
        clear_model();
        i_Start = 1;
        @(negedge clk);
        i_Start = 0;
        wait_done("dump_d2");
        chk("d2_count", tx_count, 64);
        chk("d2_errors", err_count, 0);

        // asynchronous reset in the WAIT of word 9
        start_dump();
        n = 0;
        while (!(o_TxStart && o_DebugDireccion == 9) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("f_reach_word9", o_DebugDireccion, 9);
        @(posedge clk);
        #2;
        i_reset = 0;
        #1;
        chk("f_addr", o_DebugDireccion, 0);
        chk("f_txstart", {31'h0, o_TxStart}, 0);
        chk("f_txdato", {24'h0, o_TxDato}, 0);
        chk("f_busy", {31'h0, o_Busy}, 0);
        chk("f_done", {31'h0, o_Done}, 0);
        chk("f_error", {31'h0, o_Error}, 0);
        repeat (2) @(negedge clk);
        i_reset = 1;
        n = tx_count;
        idle_check("f_post", 20, n);
        chk("f_no_done", done_count, 0);
        chk("f_no_error", err_count, 0);
        start_dump();
        wait_done("dump_f2");
        chk("f2_count", tx_count, 64);
        chk("f2_done", done_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memoria_volcado.md
MEMORIA_VOLCADO -- requirements
Module: memoria_volcado

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, data memory word width; a multiple of 8.
REQ-002 The block SHALL have parameter CELDAS, default 16, number of data memory words dumped.
REQ-003 The block SHALL have parameter TIMEOUT, default 100000, maximum cycles to wait for i_TxDone per byte.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: i_clk and i_reset.
REQ-005 i_clk  input  1  clock; all state changes on the rising edge.
REQ-006 i_reset  input  1  asynchronous active-low reset.
REQ-007 i_Start  input  1  dump request, sampled on the rising edge.
REQ-008 i_TxDone  input  1  UART transmitter single-cycle "byte sent" pulse.
REQ-009 i_DebugDato  input  NBITS  data memory debug read data; combinational from o_DebugDireccion.
REQ-010 o_DebugDireccion  output  NBITS  data memory debug word address.
REQ-011 o_TxStart  output  1  single-cycle pulse that starts transmission of o_TxDato.
REQ-012 o_TxDato  output  8  byte to transmit.
REQ-013 o_Busy  output  1  high from LOAD through DONE inclusive.
REQ-014 o_Done  output  1  single-cycle pulse at successful completion.
REQ-015 o_Error  output  1  single-cycle pulse on i_TxDone timeout.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, LOAD, SEND, WAIT, NEXT and DONE; all outputs SHALL be registered.
REQ-017 In IDLE, an i_Start sampled high SHALL clear the word counter and byte index to 0 and enter LOAD.
REQ-018 In IDLE, o_DebugDireccion SHALL be 0.
REQ-019 In LOAD, o_DebugDireccion SHALL equal the word counter; on the next edge the block SHALL latch i_DebugDato into a NBITS shift register and enter SEND.
REQ-020 In SEND, o_TxStart SHALL be 1 for exactly one cycle with o_TxDato equal to shift register bits [7:0]; the next state SHALL be WAIT and the cycle counter SHALL be cleared.
REQ-021 Byte order SHALL be LSB byte first, i.e. word bits [7:0], [15:8], and so on.
REQ-022 In WAIT, i_TxDone sampled high SHALL enter NEXT; i_TxDone SHALL be ignored in every other state.
REQ-023 In WAIT, the cycle counter SHALL increment every cycle; when it reaches TIMEOUT-1 without i_TxDone, the block SHALL pulse o_Error for one cycle, return to IDLE and leave o_Done at 0.
REQ-024 In NEXT, if the byte index is below NBITS/8-1, the block SHALL increment the index, shift the register right by 8 and enter SEND.
REQ-025 In NEXT, if the byte index equals NBITS/8-1 and the word counter is below CELDAS-1, the block SHALL clear the index, increment the word counter and enter LOAD.
REQ-026 In NEXT, if the last byte of word CELDAS-1 has been sent, the block SHALL enter DONE.
REQ-027 DONE SHALL pulse o_Done for one cycle and then enter IDLE.
REQ-028 Exactly CELDAS*NBITS/8 o_TxStart pulses SHALL be issued per completed dump.
REQ-029 The word counter SHALL never exceed CELDAS-1, with no wrap-around.
REQ-030 i_Start while o_Busy=1 SHALL be ignored, with no restart and no queuing.
REQ-031 i_Start sampled in the DONE cycle SHALL be ignored.
REQ-032 i_Start high in the first IDLE cycle after DONE or an error SHALL start a new dump.
REQ-033 Minimum per-byte latency SHALL be SEND(1) + WAIT(≥1) + NEXT(1) cycles.
REQ-034 i_DebugDato SHALL be sampled only on the LOAD edge.
REQ-035 o_TxDato SHALL hold its value from SEND until the next SEND.

Reset
REQ-036 Reset asserted (i_reset=0) SHALL asynchronously force state IDLE and clear all counters, the shift register and every output to 0.
REQ-037 Reset asserted mid-dump SHALL abort the dump with no o_Done and no o_Error.
REQ-038 After reset deasserts, the block SHALL start only on a new i_Start.

Verification
REQ-039 Memory model memory[i]=i, NBITS=32, CELDAS=16, i_TxDone pulsed 3 cycles after each o_TxStart, single i_Start -> 64 o_TxStart pulses with bytes 00 00 00 00, 01 00 00 00, ..., 0F 00 00 00, then one o_Done pulse, with o_Busy low afterwards.
REQ-040 Memory word 2 = 0xA1B2C3D4 -> bytes D4, C3, B2, A1 observed during o_DebugDireccion=2.
REQ-041 i_Start pulsed again during word 5 -> stream unchanged, still 64 bytes, and only one o_Done.
REQ-042 TIMEOUT=20, i_TxDone withheld after the 7th byte -> o_Error pulse exactly 20 cycles after the 7th WAIT is entered, o_Done stays 0, and the block is back in IDLE.
REQ-043 i_reset=0 asynchronously mid-WAIT of word 9 -> all outputs 0 immediately; a new i_Start then restarts the dump from address 0.
REQ-044 i_TxDone pulses injected during LOAD and SEND -> ignored, with no skipped bytes and no extra o_TxStart.
